// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP32 divider post-quotient stage.
// Holds the special-case code, exponent limits, packed constants and flag bit positions.
package fp_div_pkg;

    typedef enum logic [1:0] {
        SP_NORM = 2'd0,
        SP_ZERO = 2'd1,
        SP_INF  = 2'd2,
        SP_NAN  = 2'd3
    } special_e;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] INF_MAG = 32'h7F80_0000;

    localparam int FLAG_W   = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_div_round_unit.sv
// Combinational round / range-check / pack of a normalized FP32 quotient.
// FP_DIV_ROUND_RNE_EN selects round-to-nearest-even; without it the fraction is truncated.
import fp_div_pkg::*;

module fp_div_round_unit #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 23
) (
    input  logic                    i_sign,
    input  logic signed [EXP_W:0]   i_exp,
    input  logic [MANT_W-1:0]       i_frac,
    input  logic                    i_g,
    input  logic                    i_s,
    input  special_e                i_special,
    output logic [31:0]             o_result,
    output logic [FLAG_W-1:0]       o_flags
);

    localparam logic signed [EXP_W:0] L_EXP_MAX  = (EXP_W+1)'(EXP_MAX);
    localparam logic signed [EXP_W:0] L_EXP_ZERO = '0;

    logic                  w_inc;
    logic [MANT_W:0]       w_sum;
    logic                  w_carry;
    logic [MANT_W-1:0]     w_frac_r;
    logic signed [EXP_W:0] w_exp_r;

`ifdef FP_DIV_ROUND_RNE_EN
    assign w_inc = i_g & (i_s | i_frac[0]);
`else
    assign w_inc = 1'b0;
`endif

    // A carry out of the fraction means 1.111..1 rounded up to 2.0: the fraction wraps to zero
    // and the exponent absorbs the extra factor of two.
    assign w_sum    = {1'b0, i_frac} + {{MANT_W{1'b0}}, w_inc};
    assign w_carry  = w_sum[MANT_W];
    assign w_frac_r = w_sum[MANT_W-1:0];
    assign w_exp_r  = i_exp + $signed({{EXP_W{1'b0}}, w_carry});

    always_comb begin
        o_result = '0;
        o_flags  = '0;
        case (i_special)
            SP_ZERO: o_result = {i_sign, 31'd0};
            SP_INF:  o_result = {i_sign, INF_MAG[30:0]};
            SP_NAN:  o_result = QNAN;
            default: begin
                o_flags[FLAG_INX] = i_g | i_s;
                if (w_exp_r >= L_EXP_MAX) begin
                    o_result          = {i_sign, INF_MAG[30:0]};
                    o_flags[FLAG_OVF] = 1'b1;
                    o_flags[FLAG_INX] = 1'b1;
                end else if (w_exp_r <= L_EXP_ZERO) begin
                    // No subnormal support: anything below the normal range flushes to zero.
                    o_result          = {i_sign, 31'd0};
                    o_flags[FLAG_UNF] = 1'b1;
                    o_flags[FLAG_INX] = 1'b1;
                end else begin
                    o_result = {i_sign, w_exp_r[7:0], w_frac_r};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_div_norm_round.sv
// FP32 divider post-quotient stage: normalize (S1), round and pack (S2), valid/ready both sides.
// Rounding mode set by FP_DIV_ROUND_RNE_EN (defined: RNE, undefined: truncate).
import fp_div_pkg::*;

module fp_div_norm_round #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [MANT_W+2:0]       in_quot,
    input  logic                    in_sticky,
    input  logic [1:0]              in_special,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [FLAG_W-1:0]       out_flags
);

    localparam int QW = MANT_W + 3;
    localparam logic signed [EXP_W:0] L_ONE = (EXP_W+1)'(1);

    logic                  r_s1_v;
    logic                  r_s1_sign;
    logic signed [EXP_W:0] r_s1_exp;
    logic [MANT_W-1:0]     r_s1_frac;
    logic                  r_s1_g;
    logic                  r_s1_s;
    special_e              r_s1_spec;

    logic                  r_s2_v;
    logic [31:0]           r_out_result;
    logic [FLAG_W-1:0]     r_out_flags;

    logic                  w_hi;
    logic signed [EXP_W:0] w_exp_ext;
    logic signed [EXP_W:0] w_n_exp;
    logic [MANT_W-1:0]     w_n_frac;
    logic                  w_n_g;
    logic                  w_n_s;
    logic                  w_s2_free;
    logic                  w_s1_move;
    logic                  w_s1_load;
    logic [31:0]           w_rnd_result;
    logic [FLAG_W-1:0]     w_rnd_flags;

    // Quotient lies in [0.5,2): a clear integer bit means one left shift restores 1.xxx.
    assign w_hi      = in_quot[QW-1];
    assign w_exp_ext = {in_exp[EXP_W-1], in_exp};
    assign w_n_exp   = w_hi ? w_exp_ext : w_exp_ext - L_ONE;
    assign w_n_frac  = w_hi ? in_quot[QW-2:2] : in_quot[QW-3:1];
    assign w_n_g     = w_hi ? in_quot[1] : in_quot[0];
    assign w_n_s     = (w_hi & in_quot[0]) | in_sticky;

    // in_ready depends only on stage state and out_ready, never on in_valid.
    assign w_s2_free = !r_s2_v || out_ready;
    assign w_s1_move = r_s1_v && w_s2_free;
    assign in_ready  = !r_s1_v || w_s2_free;
    assign w_s1_load = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_frac <= '0;
            r_s1_g    <= 1'b0;
            r_s1_s    <= 1'b0;
            r_s1_spec <= SP_NORM;
        end else begin
            if (w_s1_load) begin
                r_s1_v    <= 1'b1;
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_n_exp;
                r_s1_frac <= w_n_frac;
                r_s1_g    <= w_n_g;
                r_s1_s    <= w_n_s;
                r_s1_spec <= special_e'(in_special);
            end else if (w_s1_move) begin
                r_s1_v <= 1'b0;
            end
        end
    end

    fp_div_round_unit #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_round (
        .i_sign    (r_s1_sign),
        .i_exp     (r_s1_exp),
        .i_frac    (r_s1_frac),
        .i_g       (r_s1_g),
        .i_s       (r_s1_s),
        .i_special (r_s1_spec),
        .o_result  (w_rnd_result),
        .o_flags   (w_rnd_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v       <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else begin
            if (w_s1_move) begin
                r_s2_v       <= 1'b1;
                r_out_result <= w_rnd_result;
                r_out_flags  <= w_rnd_flags;
            end else if (out_ready) begin
                r_s2_v <= 1'b0;
            end
        end
    end

    assign out_valid  = r_s2_v;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;

endmodule

// File: tb/tb_fp_div_norm_round.sv
// Self-checking bench for fp_div_norm_round: directed table, backpressure, reset and random streams.
// Expected values follow FP_DIV_ROUND_RNE_EN the same way the design does.
module tb_fp_div_norm_round;
    import fp_div_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sign = 1'b0;
    logic signed [9:0] in_exp = '0;
    logic [25:0]       in_quot = '0;
    logic              in_sticky = 1'b0;
    logic [1:0]        in_special = 2'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_result;
    logic [2:0]        out_flags;

    fp_div_norm_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_quot    (in_quot),
        .in_sticky  (in_sticky),
        .in_special (in_special),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        sg;
        int          e;
        logic [25:0] q;
        logic        st;
        logic [1:0]  sp;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   inflight;
    bit   pend;
    bit   stalled_prev;
    logic [31:0] prev_res;
    logic [2:0]  prev_flg;
    int   n_acc;
    int   n_emit;
    bit   saw_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: treat the quotient as an integer scaled by 2^25 and round with plain arithmetic.
    function automatic logic [34:0] ref_model(input logic sg, input int e_in, input logic [25:0] q_in,
                                              input logic st, input logic [1:0] sp);
        longint q, m, rem;
        int e;
        logic up;
        logic [31:0] r;
        logic [2:0] f;
        if (sp == 2'd1) return {sg, 31'd0, 3'b000};
        if (sp == 2'd2) return {sg, 31'h7F800000, 3'b000};
        if (sp == 2'd3) return {32'h7FC00000, 3'b000};
        q = longint'(q_in);
        e = e_in;
        if (q < 64'sd33554432) begin
            q = q * 2;
            e = e - 1;
        end
        m   = q / 4;
        rem = q % 4;
        f   = 3'b000;
        f[0] = (rem != 0) || st;
`ifdef FP_DIV_ROUND_RNE_EN
        up = (rem > 2) || (rem == 2 && (st || (m % 2 == 1)));
`else
        up = 1'b0;
`endif
        if (up) m = m + 1;
        if (m == 64'sd16777216) begin
            m = m / 2;
            e = e + 1;
        end
        if (e >= 255) begin
            r = {sg, 31'h7F800000};
            f = 3'b101;
        end else if (e <= 0) begin
            r = {sg, 31'd0};
            f = 3'b011;
        end else begin
            r = {sg, 8'(e), 23'(m % 64'sd8388608)};
        end
        return {r, f};
    endfunction

    task automatic gen_random();
        int e;
        int sp;
        in_sign = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) e = int'($urandom_range(0, 1000)) - 500;
        else e = int'($urandom_range(0, 300)) - 20;
        in_exp    = e[9:0];
        in_quot   = 26'($urandom_range(26'h3FFFFFF, 26'h1000000));
        in_sticky = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) begin
            in_quot[0] = 1'b0;
            in_sticky  = 1'b0;
        end
        sp = int'($urandom_range(0, 15));
        in_special = (sp < 12) ? 2'd0 : 2'(sp - 12);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #7;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        inflight = 0;
        pend = 1'b0;
        stalled_prev = 1'b0;
        n_acc = 0;
        n_emit = 0;
        saw_stall = 1'b0;
    endtask

    // One clock of the streaming engine; entered and left at posedge+1.
    task automatic cycle_step(input bit want_valid, input logic ordy);
        exp_t  x;
        logic [34:0] mr;
        bit fire_in, fire_out;
        if (!pend && want_valid) begin
            gen_random();
            pend = 1'b1;
        end
        in_valid  = pend;
        out_ready = ordy;
        @(negedge clk);
        fire_in  = in_valid && in_ready;
        fire_out = out_valid && out_ready;
        chk("in_ready", 32'(in_ready), 32'(!(inflight == 2 && !out_ready)));
        if (!in_ready) saw_stall = 1'b1;
        if (stalled_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, prev_res);
            chk("hold_flags", 32'(out_flags), 32'(prev_flg));
        end
        if (out_valid) chk("spurious_out", 32'(sb.size() > 0), 32'd1);
        if (fire_out && sb.size() > 0) begin
            x = sb.pop_front();
            chk("stream_result", out_result, x.res);
            chk("stream_flags", 32'(out_flags), 32'(x.flg));
            n_emit++;
            inflight--;
        end
        stalled_prev = out_valid && !out_ready;
        prev_res = out_result;
        prev_flg = out_flags;
        if (fire_in) begin
            mr = ref_model(in_sign, int'(in_exp), in_quot, in_sticky, in_special);
            x.res = mr[34:3];
            x.flg = mr[2:0];
            sb.push_back(x);
            pend = 1'b0;
            inflight++;
            n_acc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic single_op(input vec_t v, input int idx);
        int edges;
        in_sign    = v.sg;
        in_exp     = 10'(v.e);
        in_quot    = v.q;
        in_sticky  = v.st;
        in_special = v.sp;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 8) begin
            @(posedge clk); #1;
            edges++;
        end
        chk($sformatf("tbl%0d_latency", idx), 32'(edges), 32'd2);
        chk($sformatf("tbl%0d_result", idx), out_result, v.res);
        chk($sformatf("tbl%0d_flags", idx), 32'(out_flags), 32'(v.flg));
        @(posedge clk); #1;
    endtask

    vec_t tbl[13];
    bit   ptn[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int cyc;

        tbl[0] = '{1'b0, 128, 26'h3000000, 1'b0, 2'd0, 32'h40400000, 3'b000};
`ifdef FP_DIV_ROUND_RNE_EN
        tbl[1] = '{1'b0, 127, 26'h1555555, 1'b1, 2'd0, 32'h3F2AAAAB, 3'b001};
        tbl[7] = '{1'b0, 127, 26'h3FFFFFF, 1'b0, 2'd0, 32'h40000000, 3'b001};
        tbl[9] = '{1'b0, 127, 26'h2000006, 1'b0, 2'd0, 32'h3F800002, 3'b001};
        tbl[11] = '{1'b1, 254, 26'h3FFFFFF, 1'b0, 2'd0, 32'hFF800000, 3'b101};
`else
        tbl[1] = '{1'b0, 127, 26'h1555555, 1'b1, 2'd0, 32'h3F2AAAAA, 3'b001};
        tbl[7] = '{1'b0, 127, 26'h3FFFFFF, 1'b0, 2'd0, 32'h3FFFFFFF, 3'b001};
        tbl[9] = '{1'b0, 127, 26'h2000006, 1'b0, 2'd0, 32'h3F800001, 3'b001};
        tbl[11] = '{1'b1, 254, 26'h3FFFFFF, 1'b0, 2'd0, 32'hFF7FFFFF, 3'b001};
`endif
        tbl[2]  = '{1'b0, 255, 26'h2000000, 1'b0, 2'd0, 32'h7F800000, 3'b101};
        tbl[3]  = '{1'b1, 0,   26'h2000000, 1'b0, 2'd0, 32'h80000000, 3'b011};
        tbl[4]  = '{1'b1, 127, 26'h3FFFFFF, 1'b1, 2'd3, 32'h7FC00000, 3'b000};
        tbl[5]  = '{1'b1, 127, 26'h2000000, 1'b0, 2'd2, 32'hFF800000, 3'b000};
        tbl[6]  = '{1'b0, 127, 26'h2000000, 1'b1, 2'd1, 32'h00000000, 3'b000};
        tbl[8]  = '{1'b0, 127, 26'h2000002, 1'b0, 2'd0, 32'h3F800000, 3'b001};
        tbl[10] = '{1'b0, 1,   26'h1000000, 1'b0, 2'd0, 32'h00000000, 3'b011};
        tbl[12] = '{1'b1, 130, 26'h2800000, 1'b0, 2'd0, 32'hC1200000, 3'b000};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 13; i++) single_op(tbl[i], i);

        // Reset with two operations in flight
        reset_dut();
        tbl[0].sg = 1'b0;
        in_sign = 1'b0; in_exp = 10'sd128; in_quot = 26'h3000000; in_sticky = 1'b0; in_special = 2'd0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_quot = 26'h2800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_result", out_result, 32'd0);
        chk("midrst_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("postrst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("postrst_in_ready", 32'(in_ready), 32'd1);

        // Backpressure: 8 back-to-back ops, out_ready pattern 1,0,0,1
        reset_dut();
        cyc = 0;
        while ((n_acc < 8 || sb.size() > 0) && cyc < 200) begin
            cycle_step(n_acc < 8, ptn[cyc % 4]);
            cyc++;
        end
        chk("bp_drained", 32'(sb.size()), 32'd0);
        chk("bp_emitted", 32'(n_emit), 32'd8);
        chk("bp_saw_stall", 32'(saw_stall), 32'd1);

        // Random stream with random backpressure
        reset_dut();
        for (int i = 0; i < 800; i++)
            cycle_step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 9) < 6));
        cyc = 0;
        while (sb.size() > 0 && cyc < 50) begin
            cycle_step(1'b0, 1'b1);
            cyc++;
        end
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_count", 32'(n_emit), 32'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
